// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, resolves JMP/CALL/RET in fetch through a
// circular return-address stack, and bubbles while a conditional branch is pending.
module fetch_unit #(
    parameter int         PC_W      = 8,
    parameter int         RAS_DEPTH = 4,
    parameter logic [3:0] OP_BR     = 4'hC,
    parameter logic [3:0] OP_JMP    = 4'hD,
    parameter logic [3:0] OP_CALL   = 4'hE,
    parameter logic [3:0] OP_RET    = 4'hF
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic [PC_W-1:0]              imem_addr,
    input  logic [15:0]                  imem_rdata,
    input  logic                         imem_ready,
    input  logic                         stall,
    input  logic                         br_resolve,
    input  logic                         br_taken,
    input  logic [PC_W-1:0]              br_target,
    output logic [15:0]                  insn_o,
    output logic                         bubble_en,
    output logic [PC_W-1:0]              pc_o,
    output logic [PC_W-1:0]              ras_top,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_overflow,
    output logic                         ras_underflow
);

    localparam int SP_W  = $clog2(RAS_DEPTH);
    localparam int CNT_W = SP_W + 1;

    localparam logic [0:0] ST_FETCH   = 1'b0;
    localparam logic [0:0] ST_RESOLVE = 1'b1;

    logic [0:0]       state_reg, state_next;
    logic [PC_W-1:0]  pc_reg, pc_next;
    logic [SP_W-1:0]  sp_reg, sp_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             ovf_reg, unf_reg;
    logic [PC_W-1:0]  ras_mem [RAS_DEPTH];

    logic             issue;
    logic             push, pop, ret_empty;
    logic             ras_full, ras_empty;
    logic [3:0]       opcode;
    logic [PC_W-1:0]  pc_inc;
    logic [SP_W-1:0]  top_idx;

    assign issue     = (state_reg == ST_FETCH) & imem_ready & ~stall & ~rst;
    assign opcode    = imem_rdata[15:12];
    assign pc_inc    = pc_reg + PC_W'(1);
    assign top_idx   = sp_reg - SP_W'(1);
    assign ras_full  = (cnt_reg == CNT_W'(RAS_DEPTH));
    assign ras_empty = (cnt_reg == '0);

    assign imem_addr     = pc_reg;
    assign pc_o          = pc_reg;
    assign insn_o        = issue ? imem_rdata : 16'h0;
    assign bubble_en     = ~issue;
    assign ras_top       = ras_empty ? '0 : ras_mem[top_idx];
    assign ras_count     = cnt_reg;
    assign ras_overflow  = ovf_reg;
    assign ras_underflow = unf_reg;

    always_comb begin
        pc_next    = pc_reg;
        state_next = state_reg;
        push       = 1'b0;
        pop        = 1'b0;
        ret_empty  = 1'b0;
        if (state_reg == ST_RESOLVE) begin
            // Not-taken leaves pc at the fall-through already advanced past the BR.
            if (br_resolve) begin
                state_next = ST_FETCH;
                if (br_taken)
                    pc_next = br_target;
            end
        end else if (issue) begin
            case (opcode)
                OP_JMP:  pc_next = imem_rdata[PC_W-1:0];
                OP_CALL: begin
                    push    = 1'b1;
                    pc_next = imem_rdata[PC_W-1:0];
                end
                OP_RET: begin
                    if (ras_empty) begin
                        ret_empty = 1'b1;
                        pc_next   = '0;
                    end else begin
                        pop     = 1'b1;
                        pc_next = ras_mem[top_idx];
                    end
                end
                OP_BR: begin
                    pc_next    = pc_inc;
                    state_next = ST_RESOLVE;
                end
                default: pc_next = pc_inc;
            endcase
        end
    end

    always_comb begin
        sp_next  = sp_reg;
        cnt_next = cnt_reg;
        if (push) begin
            // A push while full overwrites the oldest entry; count saturates.
            sp_next  = sp_reg + SP_W'(1);
            cnt_next = ras_full ? cnt_reg : cnt_reg + CNT_W'(1);
        end else if (pop) begin
            sp_next  = top_idx;
            cnt_next = cnt_reg - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_FETCH;
            pc_reg    <= '0;
            sp_reg    <= '0;
            cnt_reg   <= '0;
            ovf_reg   <= 1'b0;
            unf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            sp_reg    <= sp_next;
            cnt_reg   <= cnt_next;
            ovf_reg   <= push & ras_full;
            unf_reg   <= ret_empty;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RAS_DEPTH; i++)
                ras_mem[i] <= '0;
        end else if (push) begin
            ras_mem[sp_reg] <= pc_inc;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: each cycle's stimulus pushes a hand-computed
// expectation; a negedge monitor pops and compares against the DUT outputs.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  imem_addr;
    logic [15:0] imem_rdata = 16'h0;
    logic        imem_ready = 1'b0;
    logic        stall = 1'b0;
    logic        br_resolve = 1'b0;
    logic        br_taken = 1'b0;
    logic [7:0]  br_target = 8'h0;
    logic [15:0] insn_o;
    logic        bubble_en;
    logic [7:0]  pc_o;
    logic [7:0]  ras_top;
    logic [2:0]  ras_count;
    logic        ras_overflow;
    logic        ras_underflow;

    fetch_unit dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .imem_ready(imem_ready), .stall(stall), .br_resolve(br_resolve),
        .br_taken(br_taken), .br_target(br_target), .insn_o(insn_o),
        .bubble_en(bubble_en), .pc_o(pc_o), .ras_top(ras_top),
        .ras_count(ras_count), .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        bub;
        logic [15:0] insn;
        logic [7:0]  pc;
        logic [7:0]  top;
        logic [2:0]  cnt;
        logic        ovf;
        logic        unf;
    } exp_t;

    exp_t exp_q[$];
    int   vectors    = 0;
    int   miscompares = 0;

    localparam logic [15:0] ADD = 16'h1000;
    localparam logic [15:0] BR  = 16'hC000;
    localparam logic [15:0] RET = 16'hF000;

    task automatic step(input logic r, input logic rdy, input logic stl, input logic [15:0] rd,
                        input logic brr, input logic brt, input logic [7:0] tg,
                        input logic ebub, input logic [7:0] epc, input logic [7:0] etop,
                        input logic [2:0] ecnt, input logic eovf, input logic eunf);
        exp_t e;
        @(posedge clk);
        #1;
        rst        = r;
        imem_ready = rdy;
        stall      = stl;
        imem_rdata = rd;
        br_resolve = brr;
        br_taken   = brt;
        br_target  = tg;
        e.bub  = ebub;
        e.insn = ebub ? 16'h0 : rd;
        e.pc   = epc;
        e.top  = etop;
        e.cnt  = ecnt;
        e.ovf  = eovf;
        e.unf  = eunf;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            vectors++;
            if (bubble_en !== e.bub || insn_o !== e.insn || pc_o !== e.pc || imem_addr !== e.pc ||
                ras_top !== e.top || ras_count !== e.cnt || ras_overflow !== e.ovf ||
                ras_underflow !== e.unf) begin
                miscompares++;
                $display("FAIL vec %0d: got bub=%0b insn=%04h pc=%02h addr=%02h top=%02h cnt=%0d ovf=%0b unf=%0b, want bub=%0b insn=%04h pc=%02h top=%02h cnt=%0d ovf=%0b unf=%0b",
                         vectors, bubble_en, insn_o, pc_o, imem_addr, ras_top, ras_count,
                         ras_overflow, ras_underflow, e.bub, e.insn, e.pc, e.top, e.cnt, e.ovf, e.unf);
            end else begin
                $display("vec %0d ok: bub=%0b insn=%04h pc=%02h top=%02h cnt=%0d ovf=%0b unf=%0b",
                         vectors, bubble_en, insn_o, pc_o, ras_top, ras_count, ras_overflow, ras_underflow);
            end
        end
    end

    initial begin
        //   rst rdy stl rdata      brr brt tgt     bub pc     top    cnt ovf unf
        // Reset and straight-line fetch
        step(1, 1, 0, ADD,       0, 0, 8'h00, 1, 8'h00, 8'h00, 0, 0, 0);
        step(0, 1, 0, ADD,       0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0);
        step(0, 1, 0, ADD,       0, 0, 8'h00, 0, 8'h01, 8'h00, 0, 0, 0);
        step(0, 1, 0, ADD,       0, 0, 8'h00, 0, 8'h02, 8'h00, 0, 0, 0);
        step(0, 1, 0, ADD,       0, 0, 8'h00, 0, 8'h03, 8'h00, 0, 0, 0);
        step(0, 1, 0, ADD,       0, 0, 8'h00, 0, 8'h04, 8'h00, 0, 0, 0);
        // Hold on imem_ready low, then on stall
        for (int i = 0; i < 3; i++)
            step(0, 0, 0, ADD,   0, 0, 8'h00, 1, 8'h05, 8'h00, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            step(0, 1, 1, ADD,   0, 0, 8'h00, 1, 8'h05, 8'h00, 0, 0, 0);
        step(0, 1, 0, ADD,       0, 0, 8'h00, 0, 8'h05, 8'h00, 0, 0, 0);
        // JMP to 0x10, CALL 0x40, RET back to 0x11
        step(0, 1, 0, 16'hD010,  0, 0, 8'h00, 0, 8'h06, 8'h00, 0, 0, 0);
        step(0, 1, 0, 16'hE040,  0, 0, 8'h00, 0, 8'h10, 8'h00, 0, 0, 0);
        step(0, 1, 0, ADD,       0, 0, 8'h00, 0, 8'h40, 8'h11, 1, 0, 0);
        step(0, 1, 0, ADD,       0, 0, 8'h00, 0, 8'h41, 8'h11, 1, 0, 0);
        step(0, 1, 0, RET,       0, 0, 8'h00, 0, 8'h42, 8'h11, 1, 0, 0);
        step(0, 1, 0, ADD,       0, 0, 8'h00, 0, 8'h11, 8'h00, 0, 0, 0);
        // Five nested CALLs overflow the 4-deep stack
        step(0, 1, 0, 16'hE050,  0, 0, 8'h00, 0, 8'h12, 8'h00, 0, 0, 0);
        step(0, 1, 0, 16'hE060,  0, 0, 8'h00, 0, 8'h50, 8'h13, 1, 0, 0);
        step(0, 1, 0, 16'hE070,  0, 0, 8'h00, 0, 8'h60, 8'h51, 2, 0, 0);
        step(0, 1, 0, 16'hE080,  0, 0, 8'h00, 0, 8'h70, 8'h61, 3, 0, 0);
        step(0, 1, 0, 16'hE090,  0, 0, 8'h00, 0, 8'h80, 8'h71, 4, 0, 0);
        // Four RETs unwind the newest four, the fifth underflows to 0
        step(0, 1, 0, RET,       0, 0, 8'h00, 0, 8'h90, 8'h81, 4, 1, 0);
        step(0, 1, 0, RET,       0, 0, 8'h00, 0, 8'h81, 8'h71, 3, 0, 0);
        step(0, 1, 0, RET,       0, 0, 8'h00, 0, 8'h71, 8'h61, 2, 0, 0);
        step(0, 1, 0, RET,       0, 0, 8'h00, 0, 8'h61, 8'h51, 1, 0, 0);
        step(0, 1, 0, RET,       0, 0, 8'h00, 0, 8'h51, 8'h00, 0, 0, 0);
        step(0, 1, 0, ADD,       0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 1);
        step(0, 1, 0, ADD,       0, 0, 8'h00, 0, 8'h01, 8'h00, 0, 0, 0);
        // Taken branch at 0x20 -> 0x80
        step(0, 1, 0, 16'hD020,  0, 0, 8'h00, 0, 8'h02, 8'h00, 0, 0, 0);
        step(0, 1, 0, BR,        0, 0, 8'h00, 0, 8'h20, 8'h00, 0, 0, 0);
        step(0, 1, 0, ADD,       0, 0, 8'h00, 1, 8'h21, 8'h00, 0, 0, 0);
        step(0, 1, 0, ADD,       1, 1, 8'h80, 1, 8'h21, 8'h00, 0, 0, 0);
        step(0, 1, 0, ADD,       0, 0, 8'h00, 0, 8'h80, 8'h00, 0, 0, 0);
        // Not-taken branch falls through to 0x21; resolves seen in FETCH are ignored
        step(0, 1, 0, 16'hD020,  0, 0, 8'h00, 0, 8'h81, 8'h00, 0, 0, 0);
        step(0, 1, 0, BR,        0, 0, 8'h00, 0, 8'h20, 8'h00, 0, 0, 0);
        step(0, 1, 0, ADD,       1, 0, 8'h80, 1, 8'h21, 8'h00, 0, 0, 0);
        step(0, 1, 0, ADD,       1, 1, 8'h80, 0, 8'h21, 8'h00, 0, 0, 0);
        step(0, 0, 0, ADD,       1, 1, 8'h80, 1, 8'h22, 8'h00, 0, 0, 0);
        step(0, 1, 0, ADD,       0, 0, 8'h00, 0, 8'h22, 8'h00, 0, 0, 0);
        // PC wrap at 0xFF, and a CALL at 0xFF pushes 0x00
        step(0, 1, 0, 16'hD0FF,  0, 0, 8'h00, 0, 8'h23, 8'h00, 0, 0, 0);
        step(0, 1, 0, ADD,       0, 0, 8'h00, 0, 8'hFF, 8'h00, 0, 0, 0);
        step(0, 1, 0, ADD,       0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0);
        step(0, 1, 0, 16'hD0FF,  0, 0, 8'h00, 0, 8'h01, 8'h00, 0, 0, 0);
        step(0, 1, 0, 16'hE030,  0, 0, 8'h00, 0, 8'hFF, 8'h00, 0, 0, 0);
        step(0, 1, 0, ADD,       0, 0, 8'h00, 0, 8'h30, 8'h00, 1, 0, 0);
        // Reset during RESOLVE discards the branch and the stack
        step(0, 1, 0, BR,        0, 0, 8'h00, 0, 8'h31, 8'h00, 1, 0, 0);
        step(0, 1, 0, ADD,       0, 0, 8'h00, 1, 8'h32, 8'h00, 1, 0, 0);
        step(1, 1, 0, ADD,       0, 0, 8'h00, 1, 8'h00, 8'h00, 0, 0, 0);
        step(1, 1, 0, ADD,       1, 1, 8'h80, 1, 8'h00, 8'h00, 0, 0, 0);
        step(0, 1, 0, ADD,       0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0);
        step(0, 1, 0, ADD,       0, 0, 8'h00, 0, 8'h01, 8'h00, 0, 0, 0);

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
